// File: rtl/bus_responder.sv
// rtl/bus_responder.sv - bus slave: system RAM, output port, reload timer and fixed reset/IRQ vectors
module bus_responder #(
    parameter int          RAM_AW       = 11,
    parameter logic [15:0] IO_BASE      = 16'hD000,
    parameter logic [15:0] RESET_VECTOR = 16'h0200,
    parameter logic [15:0] IRQ_VECTOR   = 16'h0300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        read_write,
    input  logic [7:0]  data_write,
    output logic [7:0]  data_read,
    output logic [7:0]  port_out,
    output logic        irq
);

    localparam logic [2:0] OFF_PORT = 3'd0;
    localparam logic [2:0] OFF_TLO  = 3'd1;
    localparam logic [2:0] OFF_THI  = 3'd2;
    localparam logic [2:0] OFF_CTRL = 3'd3;
    localparam logic [2:0] OFF_RLO  = 3'd4;
    localparam logic [2:0] OFF_RHI  = 3'd5;

    logic [7:0]  mem [0:(2**RAM_AW)-1];
    logic [15:0] count;
    logic [15:0] reload;
    logic [7:0]  shadow;
    logic        timer_en;
    logic        irq_en;
    logic        ovf;

    logic [15:0] io_off;
    logic        in_ram;
    logic        in_io;
    logic        in_vec;
    logic        io_wr;
    logic        underflow;

    assign io_off = address - IO_BASE;
    assign in_ram = (address >> RAM_AW) == 16'd0;
    assign in_io  = !in_ram && (io_off < 16'd6);
    assign in_vec = !in_ram && !in_io && (address >= 16'hFFFC);
    assign io_wr  = in_io && !read_write;

    // A restart write owns the counter on its edge, so it also suppresses the underflow flag.
    assign underflow = timer_en && (count == 16'd0) && !(io_wr && io_off[2:0] == OFF_TLO);

    assign irq = ovf & irq_en;

    always_comb begin
        data_read = 8'hFF;
        if (in_ram) begin
            data_read = mem[address[RAM_AW-1:0]];
        end else if (in_io) begin
            case (io_off[2:0])
                OFF_PORT: data_read = port_out;
                OFF_TLO:  data_read = count[7:0];
                OFF_THI:  data_read = shadow;
                OFF_CTRL: data_read = {ovf, 5'b00000, irq_en, timer_en};
                OFF_RLO:  data_read = reload[7:0];
                OFF_RHI:  data_read = reload[15:8];
                default:  data_read = 8'hFF;
            endcase
        end else if (in_vec) begin
            case (address[1:0])
                2'd0:    data_read = RESET_VECTOR[7:0];
                2'd1:    data_read = RESET_VECTOR[15:8];
                2'd2:    data_read = IRQ_VECTOR[7:0];
                default: data_read = IRQ_VECTOR[15:8];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !read_write && in_ram) begin
            mem[address[RAM_AW-1:0]] <= data_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            port_out <= 8'h00;
            count    <= 16'hFFFF;
            reload   <= 16'hFFFF;
            shadow   <= 8'h00;
            timer_en <= 1'b0;
            irq_en   <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            if (io_wr && io_off[2:0] == OFF_PORT) port_out       <= data_write;
            if (io_wr && io_off[2:0] == OFF_RLO)  reload[7:0]    <= data_write;
            if (io_wr && io_off[2:0] == OFF_RHI)  reload[15:8]   <= data_write;
            if (in_io && read_write && io_off[2:0] == OFF_TLO) shadow <= count[15:8];

            if (io_wr && io_off[2:0] == OFF_TLO) begin
                count <= reload;
            end else if (timer_en) begin
                count <= (count == 16'd0) ? reload : count - 16'd1;
            end

            if (io_wr && io_off[2:0] == OFF_CTRL) begin
                timer_en <= data_write[0];
                irq_en   <= data_write[1];
            end

            // Set beats clear when both land on one edge.
            if (underflow) begin
                ovf <= 1'b1;
            end else if (io_wr && io_off[2:0] == OFF_CTRL && data_write[7]) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// tb/tb_bus_responder.sv - directed vector bench for bus_responder
module tb_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        read_write;
    logic [7:0]  data_write;
    logic [7:0]  data_read;
    logic [7:0]  port_out;
    logic        irq;

    int checks = 0;
    int errors = 0;

    bus_responder dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .read_write (read_write),
        .data_write (data_write),
        .data_read  (data_read),
        .port_out   (port_out),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic        rw;
        logic [7:0]  wd;
        logic [7:0]  exp_rd;
        logic [7:0]  exp_port;
    } vec_t;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic rw, input logic [7:0] d);
        address    = a;
        read_write = rw;
        data_write = d;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        drive(a, 1'b0, d);
        step();
    endtask

    task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
        drive(a, 1'b1, 8'h00);
        check(name, {8'h00, data_read}, {8'h00, exp});
        step();
    endtask

    vec_t vecs[$];
    logic [7:0] cnt_exp[5];
    logic       irq_exp[5];

    initial begin
        vecs.push_back('{16'hFFFC, 1'b1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{16'hFFFD, 1'b1, 8'h00, 8'h02, 8'h00});
        vecs.push_back('{16'hFFFE, 1'b1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{16'hFFFF, 1'b1, 8'h00, 8'h03, 8'h00});
        vecs.push_back('{16'hD000, 1'b1, 8'h00, 8'h00, 8'h00});
        vecs.push_back('{16'h9000, 1'b1, 8'h00, 8'hFF, 8'h00});
        vecs.push_back('{16'h07FF, 1'b0, 8'hA5, 8'h00, 8'h00});
        vecs.push_back('{16'h0000, 1'b0, 8'h3C, 8'h00, 8'h00});
        vecs.push_back('{16'h07FF, 1'b1, 8'h00, 8'hA5, 8'h00});
        vecs.push_back('{16'h0000, 1'b1, 8'h00, 8'h3C, 8'h00});
        vecs.push_back('{16'h0800, 1'b0, 8'h55, 8'h00, 8'h00});
        vecs.push_back('{16'h0800, 1'b1, 8'h00, 8'hFF, 8'h00});
        vecs.push_back('{16'hD000, 1'b0, 8'h5A, 8'h00, 8'h5A});
        vecs.push_back('{16'hD000, 1'b1, 8'h00, 8'h5A, 8'h5A});
        vecs.push_back('{16'hD003, 1'b1, 8'h00, 8'h00, 8'h5A});
        vecs.push_back('{16'hD004, 1'b1, 8'h00, 8'hFF, 8'h5A});
        vecs.push_back('{16'hD005, 1'b1, 8'h00, 8'hFF, 8'h5A});
        vecs.push_back('{16'hD006, 1'b1, 8'h00, 8'hFF, 8'h5A});
        vecs.push_back('{16'hFFFC, 1'b0, 8'h12, 8'h00, 8'h5A});
        vecs.push_back('{16'hFFFC, 1'b1, 8'h00, 8'h00, 8'h5A});
        vecs.push_back('{16'hD002, 1'b0, 8'h77, 8'h00, 8'h5A});
        vecs.push_back('{16'hD002, 1'b1, 8'h00, 8'h00, 8'h5A});

        cnt_exp = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03};
        irq_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst = 1'b1;
        drive(16'h9000, 1'b1, 8'h00);
        step();
        step();
        drive(16'hFFFD, 1'b1, 8'h00);
        check("vec_during_rst", {8'h00, data_read}, 16'h0002);
        check("rst_port", {8'h00, port_out}, 16'h0000);
        check("rst_irq", {15'h0, irq}, 16'h0000);
        step();
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].a, vecs[i].rw, vecs[i].wd);
            if (vecs[i].rw) check($sformatf("vec%0d_rd", i), {8'h00, data_read}, {8'h00, vecs[i].exp_rd});
            step();
            check($sformatf("vec%0d_port", i), {8'h00, port_out}, {8'h00, vecs[i].exp_port});
        end

        drive(16'h9000, 1'b1, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("port_after_rst", {8'h00, port_out}, 16'h0000);

        // timer: reload 3, restart, enable with interrupts
        wr(16'hD004, 8'h03);
        wr(16'hD005, 8'h00);
        wr(16'hD001, 8'h00);
        wr(16'hD003, 8'h03);
        for (int i = 0; i < 5; i++) begin
            drive(16'hD001, 1'b1, 8'h00);
            check($sformatf("run_cnt%0d", i), {8'h00, data_read}, {8'h00, cnt_exp[i]});
            check($sformatf("run_irq%0d", i), {15'h0, irq}, {15'h0, irq_exp[i]});
            step();
        end
        wr(16'hD003, 8'h83);
        check("clr_irq", {15'h0, irq}, 16'h0000);
        rd_check("cnt_1", 16'hD001, 8'h01);
        rd_check("cnt_0", 16'hD001, 8'h00);
        check("reset_every4", {15'h0, irq}, 16'h0001);

        rd_check("cnt_3", 16'hD001, 8'h03);
        rd_check("cnt_2", 16'hD001, 8'h02);
        rd_check("cnt_1b", 16'hD001, 8'h01);
        wr(16'hD003, 8'h83);
        check("set_wins_irq", {15'h0, irq}, 16'h0001);
        rd_check("set_wins_ctrl", 16'hD003, 8'h83);
        wr(16'hD003, 8'h83);
        check("clear_irq", {15'h0, irq}, 16'h0000);
        rd_check("clear_ctrl", 16'hD003, 8'h03);
        drive(16'h9000, 1'b1, 8'h00);
        step();
        check("reset_irq_again", {15'h0, irq}, 16'h0001);
        wr(16'hD003, 8'h01);
        check("ie_off_irq", {15'h0, irq}, 16'h0000);
        rd_check("ovf_kept", 16'hD003, 8'h81);

        // THI shadow coherence
        wr(16'hD003, 8'h00);
        wr(16'hD004, 8'h00);
        wr(16'hD005, 8'h12);
        wr(16'hD001, 8'h00);
        rd_check("tlo_1200", 16'hD001, 8'h00);
        rd_check("thi_1200", 16'hD002, 8'h12);
        wr(16'hD003, 8'h01);
        drive(16'h9000, 1'b1, 8'h00);
        step();
        rd_check("thi_stale", 16'hD002, 8'h12);
        rd_check("tlo_11fe", 16'hD001, 8'hFE);
        rd_check("thi_11", 16'hD002, 8'h11);

        drive(16'h9000, 1'b1, 8'h00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrun_irq", {15'h0, irq}, 16'h0000);
        rd_check("midrun_thi_rst", 16'hD002, 8'h00);
        rd_check("midrun_tlo", 16'hD001, 8'hFF);
        rd_check("midrun_thi", 16'hD002, 8'hFF);
        rd_check("midrun_ctrl", 16'hD003, 8'h00);
        rd_check("midrun_tlo_hold", 16'hD001, 8'hFF);
        rd_check("midrun_rhi", 16'hD005, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
